// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser
// Pays a requested change amount as single-coin eject pulses, greedily from
// the 10, 5, 2 and 1 tubes. It tracks the coins left in each tube and reports
// any part of the amount it could not pay.
module coin_change_dispenser #(
  parameter int EJECT_CYCLES = 4,   // cycles from one eject pulse to the next SELECT
  parameter int CNT_W        = 4,   // width of each tube inventory counter
  parameter int INIT_COUNT   = 15   // coins per tube after reset or refill
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] change_amount,
  input  logic       refill,
  output logic       eject_10,
  output logic       eject_5,
  output logic       eject_2,
  output logic       eject_1,
  output logic       busy,
  output logic       done,
  output logic [6:0] shortfall,
  output logic [3:0] tube_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE
  } state_t;

  // The tube index doubles as the denomination code: 0 is the 10-tube and
  // 3 is the 1-tube, so that tube_empty comes out in {10,5,2,1} order.
  typedef enum logic [1:0] {
    D_10 = 2'd0,
    D_5  = 2'd1,
    D_2  = 2'd2,
    D_1  = 2'd3
  } denom_t;

  // The GAP phase holds EJECT_CYCLES-1 cycles. The counter is loaded with
  // one less than that and counts down to zero. With EJECT_CYCLES=1 there
  // is no GAP, and the counter stays at zero and is never read.
  localparam int GAP_W    = (EJECT_CYCLES > 2) ? $clog2(EJECT_CYCLES) : 1;
  localparam int GAP_LOAD = (EJECT_CYCLES > 1) ? EJECT_CYCLES - 2 : 0;

  state_t           state;
  state_t           state_next;
  denom_t           den;          // denomination latched in SELECT
  logic [6:0]       remaining;    // amount still to pay
  logic [CNT_W-1:0] cnt [4];      // coins left per tube
  logic [GAP_W-1:0] gap_cnt;

  logic             sel_found;
  denom_t           sel_den;

  // Coin value of a denomination code.
  function automatic logic [6:0] denom_value(input denom_t d);
    case (d)
      D_10:    denom_value = 7'd10;
      D_5:     denom_value = 7'd5;
      D_2:     denom_value = 7'd2;
      default: denom_value = 7'd1;
    endcase
  endfunction

  // Greedy pick: the largest coin that fits the remainder and is in stock.
  always_comb begin
    // NOTE: every signal gets a default before any branch. This keeps paths
    // that assign nothing from inferring a latch.
    sel_found = 1'b0;
    sel_den   = D_1;
    if (remaining >= 7'd10 && cnt[D_10] != '0) begin
      sel_found = 1'b1;
      sel_den   = D_10;
    end else if (remaining >= 7'd5 && cnt[D_5] != '0) begin
      sel_found = 1'b1;
      sel_den   = D_5;
    end else if (remaining >= 7'd2 && cnt[D_2] != '0) begin
      sel_found = 1'b1;
      sel_den   = D_2;
    end else if (remaining >= 7'd1 && cnt[D_1] != '0) begin
      sel_found = 1'b1;
      sel_den   = D_1;
    end
  end

  // State register. Reset aborts any payout in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, with no ordering races.
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (change_amount == 7'd0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        state_next = sel_found ? S_EJECT : S_DONE;
      end
      S_EJECT: begin
        if (EJECT_CYCLES > 1) begin
          state_next = S_GAP;
        end else begin
          // No GAP, so check the remainder as it stands after this coin.
          state_next = (remaining == denom_value(den)) ? S_DONE : S_SELECT;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_next = (remaining == 7'd0) ? S_DONE : S_SELECT;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Transaction datapath: remainder, shortfall, latched coin and gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= 7'd0;
      shortfall <= 7'd0;
      den       <= D_10;
      gap_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= change_amount;
            shortfall <= 7'd0;
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            den <= sel_den;
          end else begin
            shortfall <= remaining;
          end
        end
        S_EJECT: begin
          // SELECT already checked that the coin fits, so this cannot underflow.
          remaining <= remaining - denom_value(den);
          gap_cnt   <= GAP_W'(GAP_LOAD);
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tube inventory: refill in IDLE, decrement on each eject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small counter array is reset element by element, because
      // reset must leave the tubes full. Large storage arrays would usually
      // be left out of reset.
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= CNT_W'(INIT_COUNT);
      end
    end else if (state == S_IDLE && refill) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= CNT_W'(INIT_COUNT);
      end
    end else if (state == S_EJECT) begin
      // SELECT only picks a tube with a coin left, so the count stays >= 0.
      cnt[den] <= cnt[den] - CNT_W'(1);
    end
  end

  // Outputs, decoded from registered state only.
  always_comb begin
    eject_10   = (state == S_EJECT) && (den == D_10);
    eject_5    = (state == S_EJECT) && (den == D_5);
    eject_2    = (state == S_EJECT) && (den == D_2);
    eject_1    = (state == S_EJECT) && (den == D_1);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    tube_empty = {cnt[D_10] == '0, cnt[D_5] == '0, cnt[D_2] == '0, cnt[D_1] == '0};
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Testbench for coin_change_dispenser. Each transaction pushes its expected
// eject/done events, each with the exact cycle it should occur, into a
// scoreboard queue. A monitor pops and compares them as the DUT emits pulses.
module tb_coin_change_dispenser;

  localparam int EC   = 4;
  localparam int INIT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       refill = 1'b0;
  logic [6:0] change_amount = 7'd0;
  logic       eject_10, eject_5, eject_2, eject_1;
  logic       busy, done;
  logic [6:0] shortfall;
  logic [3:0] tube_empty;

  coin_change_dispenser #(
    .EJECT_CYCLES(EC),
    .CNT_W(4),
    .INIT_COUNT(INIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .change_amount(change_amount),
    .refill(refill),
    .eject_10(eject_10),
    .eject_5(eject_5),
    .eject_2(eject_2),
    .eject_1(eject_1),
    .busy(busy),
    .done(done),
    .shortfall(shortfall),
    .tube_empty(tube_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    logic [3:0] coin;     // {10,5,2,1} one-hot
    logic [6:0] sf;
    int         at;       // absolute cycle number
  } ev_t;

  typedef struct {
    int amount;
    bit refill;
    int n10, n5, n2, n1;
    int sf;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   inv[4];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [3:0] model_empty();
    return {inv[0] == 0, inv[1] == 0, inv[2] == 0, inv[3] == 0};
  endfunction

  // Monitor: every eject or done pulse must match the head of the scoreboard.
  logic [3:0] mon_ej;
  ev_t        mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ej = {eject_10, eject_5, eject_2, eject_1};
      if (mon_ej != 4'd0 || done) begin
        check("one_pulse_per_cycle", $countones({mon_ej, done}), 1);
        if (sb.size() == 0) begin
          check("unexpected_event", {done, mon_ej}, 0);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", {done, mon_ej}, {mon_e.is_done, mon_e.coin});
          check("event_cycle", cyc, mon_e.at);
          if (done) check("done_shortfall", shortfall, mon_e.sf);
        end
      end
    end
  end

  // Queue up the expected pulses of one transaction started in cycle t0.
  task automatic push_events(input int t0, input vec_t v, output int done_rel);
    int   counts[4];
    int   k;
    int   last;
    ev_t  e;
    counts = '{v.n10, v.n5, v.n2, v.n1};
    k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < counts[d]; j++) begin
        e = '{1'b0, 4'(4'b1000 >> d), 7'd0, t0 + 2 + k * (EC + 1)};
        sb.push_back(e);
        k++;
      end
    end
    if (k == 0) begin
      done_rel = (v.amount == 0) ? 1 : 2;
    end else begin
      last = 2 + (k - 1) * (EC + 1);
      done_rel = last + EC + ((v.sf != 0) ? 1 : 0);
    end
    e = '{1'b1, 4'd0, 7'(v.sf), t0 + done_rel};
    sb.push_back(e);
  endtask

  // Run one transaction. If inject_at > 0, pulse start+refill in that cycle of it.
  task automatic run_txn(input vec_t v, input int inject_at);
    int t0;
    int done_rel;
    int busy_cnt;
    bit finished;
    @(negedge clk);
    t0 = cyc;
    if (v.refill) for (int i = 0; i < 4; i++) inv[i] = INIT;
    push_events(t0, v, done_rel);
    start = 1'b1;
    refill = v.refill;
    change_amount = 7'(v.amount);
    @(posedge clk);
    #1;
    start = 1'b0;
    refill = 1'b0;
    busy_cnt = 0;
    finished = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      #1;
      if (i == inject_at) begin
        start = 1'b1;
        refill = 1'b1;
        change_amount = 7'd5;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
        refill = 1'b0;
      end
      if (busy) busy_cnt++;
      if (sb.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    check("txn_finished", finished, 1);
    if (!finished) sb.delete();
    check("busy_cycles", busy_cnt, done_rel);
    @(negedge clk);
    #1;
    check("busy_after_done", busy, 0);
    check("shortfall_held", shortfall, v.sf);
    inv[0] -= v.n10;
    inv[1] -= v.n5;
    inv[2] -= v.n2;
    inv[3] -= v.n1;
    check("tube_empty", tube_empty, model_empty());
  endtask

  initial begin
    int   t0;
    vec_t v;
    for (int i = 0; i < 4; i++) inv[i] = INIT;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ejects", {eject_10, eject_5, eject_2, eject_1}, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_tube_empty", tube_empty, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: amount, refill, expected coins {10,5,2,1}, shortfall.
    vecs.push_back('{35, 1'b0, 3, 1, 0, 0, 0});     // basic payout
    vecs.push_back('{0, 1'b0, 0, 0, 0, 0, 0});      // zero amount
    vecs.push_back('{110, 1'b0, 11, 0, 0, 0, 0});   // 10-tube down to 1
    vecs.push_back('{27, 1'b0, 1, 3, 1, 0, 0});     // last 10, then 5s and a 2
    vecs.push_back('{127, 1'b0, 0, 11, 14, 15, 29});// drain every tube
    vecs.push_back('{3, 1'b0, 0, 0, 0, 0, 3});      // all empty: no ejects
    vecs.push_back('{6, 1'b1, 0, 1, 0, 1, 0});      // refill+start together
    for (int i = 0; i < 14; i++) vecs.push_back('{1, 1'b0, 0, 0, 0, 1, 0});
    vecs.push_back('{6, 1'b0, 0, 1, 0, 0, 1});      // greedy limit, 1-tube empty
    foreach (vecs[i]) run_txn(vecs[i], -1);

    // start/refill while busy are ignored. The 1-tube stays empty.
    v = '{20, 1'b0, 2, 0, 0, 0, 0};
    run_txn(v, 4);
    repeat (20) @(negedge clk);
    #1;
    check("ignored_start_busy", busy, 0);

    // Reset during the payout of 50, after the second eject.
    @(negedge clk);
    t0 = cyc;
    sb.push_back('{1'b0, 4'b1000, 7'd0, t0 + 2});
    sb.push_back('{1'b0, 4'b1000, 7'd0, t0 + 7});
    start = 1'b1;
    change_amount = 7'd50;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ejects", {eject_10, eject_5, eject_2, eject_1}, 0);
    check("abort_shortfall", shortfall, 0);
    check("abort_tube_empty", tube_empty, 0);
    check("abort_ejects_seen", sb.size(), 0);
    sb.delete();
    for (int i = 0; i < 4; i++) inv[i] = INIT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("abort_stays_idle", busy, 0);

    // Normal operation after the abort.
    v = '{35, 1'b0, 3, 1, 0, 0, 0};
    run_txn(v, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
